hack_cpu_ctrl: RTL and testbench
================================

Name: hack_cpu_ctrl

Overview:
- Multi-cycle Hack CPU control unit and register file; the instruction-issuing initiator that drives the existing combinational `alu` block's six control bits and consumes its out/zr/ng results.
- Fetches 16-bit Hack instructions, decodes A- and C-instructions, sequences data-memory reads and writes over ready-handshaked buses, and updates A, D and PC.

Parameters:
- DATA_W, 16, datapath and instruction width.
- ADDR_W, 15, instruction and data address width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  ADDR_W  fetch address (= PC).
- imem_valid  input  1  imem_rdata valid this cycle.
- imem_rdata  input  DATA_W  fetched instruction.
- dmem_rd  output  1  data read request.
- dmem_we  output  1  data write request.
- dmem_addr  output  ADDR_W  data address.
- dmem_wdata  output  DATA_W  write data.
- dmem_ready  input  1  completes the current read or write.
- dmem_rdata  input  DATA_W  read data, valid when dmem_ready=1.
- pc  output  ADDR_W  current PC.
- a_reg  output  DATA_W  A register, for debug and verification.
- d_reg  output  DATA_W  D register, for debug and verification.
- instr_retired  output  1  one-cycle pulse when an instruction completes.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: pc=RESET_PC, A=0, D=0, IR=0, MDR=0, dmem_we=0, dmem_rd=0, instr_retired=0, state=FETCH.
- Reset mid-operation: any outstanding request is dropped at the reset edge. No partial register update.
- States: FETCH, DECODE, MREAD, EXEC, MWRITE.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid, IR<=imem_rdata and go to DECODE. Otherwise stay.
- DECODE:
  - IR[15]=0 (A-instruction): A<={1'b0,IR[14:0]}, pc<=pc+1, pulse instr_retired, go to FETCH.
  - IR[15]=1 and IR[12]=1 (a-bit): go to MREAD.
  - Otherwise go to EXEC.
  - IR[14:13] are ignored.
- MREAD:
  - dmem_rd=1, dmem_addr=A[14:0].
  - On dmem_ready, MDR<=dmem_rdata and go to EXEC.
- EXEC:
  - alu x=D, y=(IR[12] ? MDR : A).
  - alu controls: zx=IR[11], nx=IR[10], zy=IR[9], ny=IR[8], f=IR[7], no=IR[6].
  - Register writes: d1=IR[5] writes A<=out; d2=IR[4] writes D<=out.
  - d3=IR[3] latches dmem_addr<=old A[14:0] and dmem_wdata<=out, then goes to MWRITE.
  - Otherwise pulses instr_retired and goes to FETCH.
  - Jump condition: (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr). Taken: pc<=old A[14:0]. Not taken: pc<=pc+1.
  - Old A means the value before this instruction. This applies to both the jump target and the write address, even when d1=1.
- MWRITE:
  - dmem_we=1 with address and data held stable until dmem_ready.
  - On dmem_ready, pulse instr_retired and go to FETCH.
- Arithmetic: 16-bit two's complement with wrap, done in the ALU. pc+1 wraps 0x7FFF→0x0000.
- dmem_rd and dmem_we are never asserted together. imem_req is asserted only in FETCH.
- Latency:
  - A-instruction: 2 cycles plus fetch wait.
  - C-instruction without memory access: 3 cycles.
  - Each memory access adds 1 cycle plus wait states.

Decomposition:
- Shared package: state enum; IR field index constants (A_BIT=12, COMP_HI=11, COMP_LO=6, DEST_A=5, DEST_D=4, DEST_M=3, J_LT=2, J_EQ=1, J_GT=0).
- One sub-module: the existing `alu`, instantiated unchanged.
- FSM and registers stay in this module.

Test Plan:
- Reset: assert rst for 2 cycles, then release. Required: pc=0, imem_req=1, dmem_we=0, dmem_rd=0, a_reg=0, d_reg=0.
- Program 0x0005, 0xEC10 (D=A), zero-wait imem. Required: a_reg=5, d_reg=5, pc=2, two instr_retired pulses; 0xEC10 retires 3 cycles after its fetch.
- Continue with 0xE7D0 (D=D+1). Required: d_reg=6, pc=3.
- Program 0x0064, 0xE308 (M=D) with D=6, dmem_ready held low 3 cycles. Required: dmem_we=1 with addr=100 and wdata=6 held stable all 4 cycles; retires on ready.
- Program 0x0064, 0xFC10 (D=M) with dmem_rdata=0x8000. Required: dmem_rd with addr=100, d_reg=0x8000, no dmem_we.
- Jumps:
  - With D=0x8000: 0x000A then 0xE304 (D;JLT). Required: pc=10.
  - With D=0: same pair. Required: pc=old pc+1.
  - 0xEA87 (0;JMP). Required: always jumps to A.
- Reset asserted during MWRITE. Required: dmem_we=0 on the next cycle, state FETCH, pc=0.

Source files
------------

// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared definitions for the Hack CPU control unit.
//   - state_t   : control FSM states
//   - IR field bit positions for C-instructions
//   - jump_taken: evaluates the j1..j3 jump bits against the ALU flags
package hack_cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MREAD  = 3'd2,
        EXEC   = 3'd3,
        MWRITE = 3'd4
    } state_t;

    localparam int C_BIT   = 15;
    localparam int A_BIT   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int J_LT    = 2;
    localparam int J_EQ    = 1;
    localparam int J_GT    = 0;

    function automatic logic jump_taken(input logic [2:0] jbits,
                                        input logic zr, input logic ng);
        return (jbits[J_LT] & ng) | (jbits[J_EQ] & zr) | (jbits[J_GT] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cpu_ctrl_alu.sv
// Hack ALU (combinational).
//   x, y          : operands
//   zx,nx,zy,ny   : zero / negate each operand before the function
//   f             : 1 = x + y, 0 = x & y
//   no            : negate the result
//   out, zr, ng   : result, result==0, result<0
module alu #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         zx,
    input  logic         nx,
    input  logic         zy,
    input  logic         ny,
    input  logic         f,
    input  logic         no,
    output logic [W-1:0] out,
    output logic         zr,
    output logic         ng
);

    logic [W-1:0] x1;
    logic [W-1:0] y1;
    logic [W-1:0] r;

    always_comb begin
        x1  = zx ? '0 : x;
        x1  = nx ? ~x1 : x1;
        y1  = zy ? '0 : y;
        y1  = ny ? ~y1 : y1;
        r   = f ? (x1 + y1) : (x1 & y1);
        out = no ? ~r : r;
        zr  = (out == '0);
        ng  = out[W-1];
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control unit with A/D/PC registers.
//   clk, rst            : clock, synchronous active-high reset
//   imem_req/addr       : instruction fetch request at PC (asserted only in FETCH)
//   imem_valid/rdata    : fetched instruction, accepted the cycle valid is high
//   dmem_rd/we/addr/wdata : data memory request; held stable until dmem_ready
//   dmem_ready/rdata    : completes the current access; rdata valid with ready
//   pc, a_reg, d_reg    : architectural state for observation
//   instr_retired       : one-cycle pulse the cycle after an instruction completes
//
// Handshake: a data request (dmem_rd or dmem_we, never both) stays asserted
// with constant address/data until the cycle in which dmem_ready=1; that cycle
// completes the transfer. Fetch is the same with imem_req/imem_valid.
module hack_cpu_ctrl
    import hack_cpu_ctrl_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 15,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dmem_rd,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] a_reg,
    output logic [DATA_W-1:0] d_reg,
    output logic              instr_retired
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mdr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zr;
    logic              alu_ng;
    logic              take_jump;
    logic              unused_ir_bits;

    // The two bits between the C marker and the a-bit carry no meaning.
    assign unused_ir_bits = ^ir[14:13];

    assign alu_y     = ir[A_BIT] ? mdr : a_reg;
    assign take_jump = jump_taken(ir[J_LT:J_GT], alu_zr, alu_ng);

    alu #(.W(DATA_W)) u_alu (
        .x   (d_reg),
        .y   (alu_y),
        .zx  (ir[COMP_HI]),
        .nx  (ir[COMP_HI-1]),
        .zy  (ir[COMP_HI-2]),
        .ny  (ir[COMP_HI-3]),
        .f   (ir[COMP_HI-4]),
        .no  (ir[COMP_LO]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    assign imem_addr  = pc;
    assign dmem_wdata = wr_data;

    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        dmem_rd    = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = wr_addr;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) next_state = DECODE;
            end
            DECODE: begin
                if (!ir[C_BIT])     next_state = FETCH;
                else if (ir[A_BIT]) next_state = MREAD;
                else                next_state = EXEC;
            end
            MREAD: begin
                dmem_rd   = 1'b1;
                dmem_addr = a_reg[ADDR_W-1:0];
                if (dmem_ready) next_state = EXEC;
            end
            EXEC: begin
                next_state = ir[DEST_M] ? MWRITE : FETCH;
            end
            MWRITE: begin
                dmem_we = 1'b1;
                if (dmem_ready) next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // All register updates in EXEC use nonblocking reads of a_reg, so the
    // jump target and write address see A from before this instruction even
    // when the instruction also writes A.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= ADDR_W'(RESET_PC);
            a_reg         <= '0;
            d_reg         <= '0;
            ir            <= '0;
            mdr           <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
            instr_retired <= 1'b0;
        end else begin
            state         <= next_state;
            instr_retired <= 1'b0;
            case (state)
                FETCH: begin
                    if (imem_valid) ir <= imem_rdata;
                end
                DECODE: begin
                    if (!ir[C_BIT]) begin
                        a_reg         <= {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
                        pc            <= pc + ADDR_W'(1);
                        instr_retired <= 1'b1;
                    end
                end
                MREAD: begin
                    if (dmem_ready) mdr <= dmem_rdata;
                end
                EXEC: begin
                    if (ir[DEST_A]) a_reg <= alu_out;
                    if (ir[DEST_D]) d_reg <= alu_out;
                    if (ir[DEST_M]) begin
                        wr_addr <= a_reg[ADDR_W-1:0];
                        wr_data <= alu_out;
                    end else begin
                        instr_retired <= 1'b1;
                    end
                    pc <= take_jump ? a_reg[ADDR_W-1:0] : pc + ADDR_W'(1);
                end
                MWRITE: begin
                    if (dmem_ready) instr_retired <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: zero-wait instruction memory backed by a
// small program table, a data-memory responder with configurable wait states,
// and an expected-write queue checked as writes complete.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        dmem_rd;
  logic        dmem_we;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ready;
  logic [15:0] dmem_rdata;
  logic [14:0] pc;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic        instr_retired;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.DATA_W(16), .ADDR_W(15), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_rd(dmem_rd), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .instr_retired(instr_retired)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction memory: zero wait states.
  logic [15:0] prog [0:31];
  always_comb begin
    imem_valid = imem_req;
    imem_rdata = prog[imem_addr[4:0]];
  end

  // Cycle bookkeeping.
  int cyc = 0;
  int ret_cnt = 0;
  int ret_cyc [0:63];
  int fetch_cyc [0:31];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (imem_req && imem_valid) fetch_cyc[imem_addr[4:0]] = cyc;
    if (instr_retired) begin
      ret_cyc[ret_cnt] = cyc;
      ret_cnt++;
    end
  end

  // Data memory responder and write scoreboard ({addr, data}).
  logic [30:0] exp_q [$];
  int          dmem_wait = 0;
  logic [15:0] rd_val    = 16'h0000;
  int          cnt       = 0;
  int          we_cyc    = 0;
  int          last_we_cyc = 0;
  int          wr_count  = 0;
  logic [14:0] hold_addr;
  logic [15:0] hold_data;
  logic [14:0] last_rd_addr = 15'h0;
  logic        unstable  = 1'b0;
  logic        overlap   = 1'b0;

  always @(negedge clk) begin
    if (dmem_rd && dmem_we) overlap = 1'b1;
    if (!(dmem_rd || dmem_we) || dmem_ready) begin
      dmem_ready = 1'b0;
      cnt        = 0;
      we_cyc     = 0;
    end else begin
      if (dmem_we) begin
        if (we_cyc == 0) begin
          hold_addr = dmem_addr;
          hold_data = dmem_wdata;
        end else if (dmem_addr !== hold_addr || dmem_wdata !== hold_data) begin
          unstable = 1'b1;
        end
        we_cyc++;
        last_we_cyc = we_cyc;
      end
      if (cnt == dmem_wait) begin
        dmem_ready = 1'b1;
        dmem_rdata = rd_val;
        if (dmem_rd) last_rd_addr = dmem_addr;
        if (dmem_we) begin
          wr_count++;
          if (exp_q.size() == 0) check("unexpected_write", {1'b0, dmem_addr, dmem_wdata}, 32'h0);
          else check("write_data", {1'b0, dmem_addr, dmem_wdata}, {1'b0, exp_q.pop_front()});
        end
      end else begin
        cnt++;
      end
    end
  end

  task automatic run_retires(input int n, input string tag);
    int target;
    int budget;
    target = ret_cnt + n;
    budget = 0;
    while (ret_cnt < target && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check({tag, "_retired"}, ret_cnt, target);
  endtask

  initial begin
    int budget;
    int wr_before;
    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 16'h0;
    for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
    prog[0]  = 16'h0005;  // @5
    prog[1]  = 16'hEC10;  // D=A
    prog[2]  = 16'hE7D0;  // D=D+1
    prog[3]  = 16'h0064;  // @100
    prog[4]  = 16'hE308;  // M=D
    prog[5]  = 16'h0064;  // @100
    prog[6]  = 16'hFC10;  // D=M
    prog[7]  = 16'h000A;  // @10
    prog[8]  = 16'hE304;  // D;JLT
    prog[10] = 16'hEA90;  // D=0
    prog[11] = 16'h000A;  // @10
    prog[12] = 16'hE304;  // D;JLT
    prog[13] = 16'h0014;  // @20
    prog[14] = 16'hEA87;  // 0;JMP
    prog[20] = 16'h0003;  // @3
    prog[21] = 16'hEFE7;  // A=1;JMP  (target is the old A)

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_pc", pc, 0);
    check("rst_imem_req", imem_req, 1);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_rd", dmem_rd, 0);
    check("rst_a", a_reg, 0);
    check("rst_d", d_reg, 0);
    check("rst_retired", instr_retired, 0);

    run_retires(2, "d_eq_a");
    check("d_eq_a_a", a_reg, 16'd5);
    check("d_eq_a_d", d_reg, 16'd5);
    check("d_eq_a_pc", pc, 2);
    check("c_latency", ret_cyc[1] - fetch_cyc[1], 3);

    run_retires(1, "d_inc");
    check("d_inc_d", d_reg, 16'd6);
    check("d_inc_pc", pc, 3);

    dmem_wait = 3;
    exp_q.push_back({15'd100, 16'd6});
    run_retires(2, "m_eq_d");
    check("m_eq_d_we_cycles", last_we_cyc, 4);
    check("m_eq_d_stable", unstable, 0);
    check("m_eq_d_q_empty", exp_q.size(), 0);
    check("m_eq_d_pc", pc, 5);

    dmem_wait = 0;
    rd_val    = 16'h8000;
    wr_before = wr_count;
    run_retires(2, "d_eq_m");
    check("d_eq_m_d", d_reg, 16'h8000);
    check("d_eq_m_addr", last_rd_addr, 15'd100);
    check("d_eq_m_no_write", wr_count, wr_before);
    check("d_eq_m_pc", pc, 7);

    run_retires(2, "jlt_taken");
    check("jlt_taken_pc", pc, 10);

    run_retires(1, "d_zero");
    check("d_zero_d", d_reg, 0);
    check("d_zero_pc", pc, 11);

    run_retires(2, "jlt_not_taken");
    check("jlt_not_taken_pc", pc, 13);

    run_retires(2, "jmp");
    check("jmp_pc", pc, 20);
    check("jmp_a", a_reg, 16'd20);

    run_retires(2, "old_a_jump");
    check("old_a_jump_a", a_reg, 16'd1);
    check("old_a_jump_pc", pc, 3);

    // Program resumes at 3: @100, M=D with a slow memory, reset mid-write.
    dmem_wait = 20;
    budget = 0;
    while (!dmem_we && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check("mw_reached", dmem_we, 1);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mw_rst_we", dmem_we, 0);
    check("mw_rst_rd", dmem_rd, 0);
    check("mw_rst_fetch", imem_req, 1);
    check("mw_rst_pc", pc, 0);
    check("mw_rst_a", a_reg, 0);
    check("mw_rst_d", d_reg, 0);
    rst = 1'b0;
    dmem_wait = 0;

    run_retires(1, "post_rst");
    check("post_rst_a", a_reg, 16'd5);
    check("post_rst_pc", pc, 1);
    check("rd_we_exclusive", overlap, 0);
    check("no_stray_write", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
